// File: rtl/nn_layer_sequencer_if.sv
// Stream and neuron-bus signals of the 4-2-1 layer sequencer.
// The slave side is the sequencer; the master side is its environment.
interface nn_layer_sequencer_if;
    logic signed [7:0]  X1, X2, X3, X4;
    logic               valid;
    logic               ready;
    logic signed [7:0]  Y;
    logic               valid_out;
    logic               ready_out;
    logic signed [7:0]  nrn_x1, nrn_x2, nrn_x3, nrn_x4;
    logic signed [7:0]  nrn_w1, nrn_w2, nrn_w3, nrn_w4;
    logic signed [15:0] nrn_bias;
    logic signed [11:0] nrn_xmin;
    logic signed [11:0] nrn_xmax;
    logic signed [7:0]  nrn_y;

    modport slave (
        input  X1, X2, X3, X4, valid, ready_out, nrn_y,
        output ready, Y, valid_out,
        output nrn_x1, nrn_x2, nrn_x3, nrn_x4,
        output nrn_w1, nrn_w2, nrn_w3, nrn_w4,
        output nrn_bias, nrn_xmin, nrn_xmax
    );

    modport master (
        output X1, X2, X3, X4, valid, ready_out, nrn_y,
        input  ready, Y, valid_out,
        input  nrn_x1, nrn_x2, nrn_x3, nrn_x4,
        input  nrn_w1, nrn_w2, nrn_w3, nrn_w4,
        input  nrn_bias, nrn_xmin, nrn_xmax
    );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Time-multiplexes one external combinational neuron over a 4-2-1 network.
// All outputs are registered from the next-state values, so they track the state one-for-one.
module nn_layer_sequencer #(
    parameter logic signed [7:0]  N1_W1   = -8'sd115,
    parameter logic signed [7:0]  N1_W2   = 8'sd1,
    parameter logic signed [7:0]  N1_W3   = -8'sd105,
    parameter logic signed [7:0]  N1_W4   = 8'sd16,
    parameter logic signed [7:0]  N2_W1   = 8'sd103,
    parameter logic signed [7:0]  N2_W2   = -8'sd22,
    parameter logic signed [7:0]  N2_W3   = 8'sd32,
    parameter logic signed [7:0]  N2_W4   = -8'sd56,
    parameter logic signed [7:0]  N3_W1   = 8'sd75,
    parameter logic signed [7:0]  N3_W2   = -8'sd85,
    parameter logic signed [7:0]  N3_W3   = -8'sd38,
    parameter logic signed [7:0]  N3_W4   = 8'sd92,
    parameter logic signed [15:0] N1_BIAS = 16'sd12571,
    parameter logic signed [15:0] N2_BIAS = -16'sd8139,
    parameter logic signed [15:0] N3_BIAS = 16'sd10182,
    parameter logic signed [11:0] N1_XMIN = -12'sd127,
    parameter logic signed [11:0] N1_XMAX = 12'sd127,
    parameter logic signed [11:0] N2_XMIN = -12'sd127,
    parameter logic signed [11:0] N2_XMAX = 12'sd127,
    parameter logic signed [11:0] N3_XMIN = -12'sd127,
    parameter logic signed [11:0] N3_XMAX = 12'sd127
) (
    input  logic                 clk,
    input  logic                 arst,
    nn_layer_sequencer_if.slave  bus,
    output logic                 busy,
    output logic [15:0]          infer_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_H1   = 3'd1,
        S_H2   = 3'd2,
        S_O3   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [3:0][7:0] xr_q, xr_d;
    logic [7:0]      s1_q, s1_d, s2_q, s2_d, y_q, y_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [3:0][7:0] nrn_x_q, nrn_x_d, nrn_w_q, nrn_w_d;
    logic [15:0]     nrn_bias_q, nrn_bias_d;
    logic [11:0]     nrn_xmin_q, nrn_xmin_d, nrn_xmax_q, nrn_xmax_d;
    logic            ready_q, ready_d, valid_out_q, valid_out_d, busy_q, busy_d;

    // Phase sequencing and capture of the neuron result for the current phase.
    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.valid) begin
                    xr_d    = {bus.X4, bus.X3, bus.X2, bus.X1};
                    state_d = S_H1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_H1: begin
                s1_d    = bus.nrn_y;
                state_d = S_H2;
            end
            S_H2: begin
                s2_d    = bus.nrn_y;
                state_d = S_O3;
            end
            S_O3: begin
                y_d     = bus.nrn_y;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.ready_out) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operands for the phase being entered; IDLE and DONE park the bus at zero.
    always_comb begin
        nrn_x_d    = 32'd0;
        nrn_w_d    = 32'd0;
        nrn_bias_d = 16'd0;
        nrn_xmin_d = 12'd0;
        nrn_xmax_d = 12'd0;
        case (state_d)
            S_H1: begin
                nrn_x_d    = xr_d;
                nrn_w_d    = {N1_W4, N1_W3, N1_W2, N1_W1};
                nrn_bias_d = N1_BIAS;
                nrn_xmin_d = N1_XMIN;
                nrn_xmax_d = N1_XMAX;
            end
            S_H2: begin
                nrn_x_d    = xr_d;
                nrn_w_d    = {N2_W4, N2_W3, N2_W2, N2_W1};
                nrn_bias_d = N2_BIAS;
                nrn_xmin_d = N2_XMIN;
                nrn_xmax_d = N2_XMAX;
            end
            S_O3: begin
                nrn_x_d    = {8'd0, 8'd0, s2_d, s1_d};
                nrn_w_d    = {N3_W4, N3_W3, N3_W2, N3_W1};
                nrn_bias_d = N3_BIAS;
                nrn_xmin_d = N3_XMIN;
                nrn_xmax_d = N3_XMAX;
            end
            default: begin
                nrn_x_d    = 32'd0;
                nrn_w_d    = 32'd0;
                nrn_bias_d = 16'd0;
                nrn_xmin_d = 12'd0;
                nrn_xmax_d = 12'd0;
            end
        endcase
        ready_d     = (state_d == S_IDLE);
        valid_out_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            xr_q        <= 32'd0;
            s1_q        <= 8'd0;
            s2_q        <= 8'd0;
            y_q         <= 8'd0;
            cnt_q       <= 16'd0;
            nrn_x_q     <= 32'd0;
            nrn_w_q     <= 32'd0;
            nrn_bias_q  <= 16'd0;
            nrn_xmin_q  <= 12'd0;
            nrn_xmax_q  <= 12'd0;
            ready_q     <= 1'b1;
            valid_out_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            xr_q        <= xr_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            nrn_x_q     <= nrn_x_d;
            nrn_w_q     <= nrn_w_d;
            nrn_bias_q  <= nrn_bias_d;
            nrn_xmin_q  <= nrn_xmin_d;
            nrn_xmax_q  <= nrn_xmax_d;
            ready_q     <= ready_d;
            valid_out_q <= valid_out_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.valid_out = valid_out_q;
    assign bus.Y         = y_q;
    assign bus.nrn_x1    = nrn_x_q[0];
    assign bus.nrn_x2    = nrn_x_q[1];
    assign bus.nrn_x3    = nrn_x_q[2];
    assign bus.nrn_x4    = nrn_x_q[3];
    assign bus.nrn_w1    = nrn_w_q[0];
    assign bus.nrn_w2    = nrn_w_q[1];
    assign bus.nrn_w3    = nrn_w_q[2];
    assign bus.nrn_w4    = nrn_w_q[3];
    assign bus.nrn_bias  = nrn_bias_q;
    assign bus.nrn_xmin  = nrn_xmin_q;
    assign bus.nrn_xmax  = nrn_xmax_q;
    assign busy          = busy_q;
    assign infer_cnt     = cnt_q;

endmodule
